// File: rtl/pll_reconfig_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pll_reconfig_pkg
// Description : Shared definitions for the PLL reconfiguration controller:
//               pll_cfg register map, sequencer states, handshake window.
// Revision    : 1.0 - initial release
// ============================================================================
package pll_reconfig_pkg;

    // pll_cfg management register addresses
    localparam logic [5:0] REG_MODE  = 6'd0;
    localparam logic [5:0] REG_START = 6'd2;
    localparam logic [5:0] REG_KFRAC = 6'd7;

    // Cycles to wait for waitrequest to rise after START before assuming
    // the reconfiguration already completed.
    localparam int WAITREQ_RISE_WINDOW = 16;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        MODE      = 4'd1,
        GAP1      = 4'd2,
        KFRAC     = 4'd3,
        GAP2      = 4'd4,
        START     = 4'd5,
        WAIT_BUSY = 4'd6,
        WAIT_LOCK = 4'd7,
        DONE      = 4'd8
    } state_t;

endpackage
`default_nettype wire

// File: rtl/pll_reconfig_ctrl_sel_sync.sv
`default_nettype none
// ============================================================================
// Module      : sel_sync_stable
// Description : Two-flop synchronizer followed by a stability filter. The
//               output follows the synchronized input only after it has
//               matched its previous value on two consecutive cycles, so a
//               single-cycle glitch never reaches the output.
// Revision    : 1.0 - initial release
// ============================================================================
module sel_sync_stable (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic valid
);

    logic       r_s1;
    logic       r_s2;
    logic       r_s3;
    logic       r_same_d;
    logic       r_stable;
    logic       r_valid;
    logic [1:0] r_fill;
    logic       w_primed;
    logic       w_same;

    // The pipeline holds reset values, not real samples, until three edges
    // have passed; comparisons before that would validate stale zeros.
    assign w_primed = (r_fill == 2'd3);
    assign w_same   = w_primed && (r_s2 == r_s3);

    // Synchronizer, history register and stability filter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1     <= 1'b0;
            r_s2     <= 1'b0;
            r_s3     <= 1'b0;
            r_same_d <= 1'b0;
            r_stable <= 1'b0;
            r_valid  <= 1'b0;
            r_fill   <= 2'd0;
        end else begin
            r_s1     <= din;
            r_s2     <= r_s1;
            r_s3     <= r_s2;
            r_same_d <= w_same;
            if (!w_primed) begin
                r_fill <= r_fill + 2'd1;
            end
            if (w_same && r_same_d) begin
                r_stable <= r_s2;
                r_valid  <= 1'b1;
            end
        end
    end

    assign dout  = r_stable;
    assign valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/pll_reconfig_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pll_reconfig_ctrl
// Description : Sequences the pll_cfg Avalon-MM management port to switch
//               the PLL between two fractional-K clock profiles, then waits
//               for reconfiguration to finish and the PLL to relock.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_reconfig_ctrl
    import pll_reconfig_pkg::*;
#(
    parameter logic [31:0] K_PROFILE0   = 32'd3639383488,
    parameter logic [31:0] K_PROFILE1   = 32'd3268298314,
    parameter int          GAP_CYCLES   = 2,        // must be >= 1
    parameter int          LOCK_TIMEOUT = 1048576,
    parameter bit          FORCE_INIT   = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic        mgmt_waitrequest,
    output logic        mgmt_write,
    output logic [5:0]  mgmt_address,
    output logic [31:0] mgmt_writedata,
    input  logic        pll_locked,
    output logic        busy,
    output logic        done,
    output logic        applied_sel,
    output logic        lock_err
);

    localparam int              TO_W     = $clog2(LOCK_TIMEOUT) + 1;
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(LOCK_TIMEOUT - 1);
    localparam int              GAP_W    = $clog2(GAP_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam int              WIN_W    = $clog2(WAITREQ_RISE_WINDOW);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WAITREQ_RISE_WINDOW - 1);

    // Registered state
    state_t            r_state;
    logic              r_target;
    logic              r_init_pending;
    logic              r_busy;
    logic              r_done;
    logic              r_applied;
    logic              r_lock_err;
    logic              r_write;
    logic [5:0]        r_addr;
    logic [31:0]       r_data;
    logic [GAP_W-1:0]  r_gap_cnt;
    logic [WIN_W-1:0]  r_win_cnt;
    logic              r_seen_busy;
    logic [TO_W-1:0]   r_to_cnt;
    logic              r_lock_s1;
    logic              r_lock_s2;

    // Next-state values
    state_t            w_state_nxt;
    logic              w_target_nxt;
    logic              w_init_nxt;
    logic              w_busy_nxt;
    logic              w_done_nxt;
    logic              w_applied_nxt;
    logic              w_lock_err_nxt;
    logic              w_write_nxt;
    logic [5:0]        w_addr_nxt;
    logic [31:0]       w_data_nxt;
    logic [GAP_W-1:0]  w_gap_nxt;
    logic [WIN_W-1:0]  w_win_nxt;
    logic              w_seen_nxt;
    logic [TO_W-1:0]   w_to_nxt;

    logic              w_sel_stable;
    logic              w_sel_valid;
    logic              w_request;

    sel_sync_stable u_sel_sync (
        .clk   (clk),
        .reset (reset),
        .din   (sel),
        .dout  (w_sel_stable),
        .valid (w_sel_valid)
    );

    // Holding off until the filter has produced a real sample makes the
    // post-reset init sequence program the actual select, not its reset value.
    assign w_request = w_sel_valid && ((w_sel_stable != r_applied) || r_init_pending);

    // Lock indicator synchronizer
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lock_s1 <= 1'b0;
            r_lock_s2 <= 1'b0;
        end else begin
            r_lock_s1 <= pll_locked;
            r_lock_s2 <= r_lock_s1;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= IDLE;
            r_target       <= 1'b0;
            r_init_pending <= FORCE_INIT;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_applied      <= 1'b0;
            r_lock_err     <= 1'b0;
            r_write        <= 1'b0;
            r_addr         <= 6'd0;
            r_data         <= 32'd0;
            r_gap_cnt      <= '0;
            r_win_cnt      <= '0;
            r_seen_busy    <= 1'b0;
            r_to_cnt       <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_target       <= w_target_nxt;
            r_init_pending <= w_init_nxt;
            r_busy         <= w_busy_nxt;
            r_done         <= w_done_nxt;
            r_applied      <= w_applied_nxt;
            r_lock_err     <= w_lock_err_nxt;
            r_write        <= w_write_nxt;
            r_addr         <= w_addr_nxt;
            r_data         <= w_data_nxt;
            r_gap_cnt      <= w_gap_nxt;
            r_win_cnt      <= w_win_nxt;
            r_seen_busy    <= w_seen_nxt;
            r_to_cnt       <= w_to_nxt;
        end
    end

    // Sequencer next-state logic. A write is launched when waitrequest is
    // sampled low; the registered strobe then lasts exactly one cycle and the
    // bus returns to zero because the write fields default to zero.
    always_comb begin
        w_state_nxt    = r_state;
        w_target_nxt   = r_target;
        w_init_nxt     = r_init_pending;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_applied_nxt  = r_applied;
        w_lock_err_nxt = r_lock_err;
        w_write_nxt    = 1'b0;
        w_addr_nxt     = 6'd0;
        w_data_nxt     = 32'd0;
        w_gap_nxt      = r_gap_cnt;
        w_win_nxt      = r_win_cnt;
        w_seen_nxt     = r_seen_busy;
        w_to_nxt       = r_to_cnt;

        case (r_state)
            IDLE: begin
                if (w_request) begin
                    w_target_nxt = w_sel_stable;
                    w_busy_nxt   = 1'b1;
                    w_init_nxt   = 1'b0;
                    w_state_nxt  = MODE;
                end
            end
            MODE: begin
                if (!mgmt_waitrequest) begin
                    w_write_nxt = 1'b1;
                    w_addr_nxt  = REG_MODE;
                    w_gap_nxt   = '0;
                    w_state_nxt = GAP1;
                end
            end
            GAP1: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_state_nxt = KFRAC;
                end else begin
                    w_gap_nxt = r_gap_cnt + GAP_W'(1);
                end
            end
            KFRAC: begin
                if (!mgmt_waitrequest) begin
                    w_write_nxt = 1'b1;
                    w_addr_nxt  = REG_KFRAC;
                    w_data_nxt  = r_target ? K_PROFILE1 : K_PROFILE0;
                    w_gap_nxt   = '0;
                    w_state_nxt = GAP2;
                end
            end
            GAP2: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_state_nxt = START;
                end else begin
                    w_gap_nxt = r_gap_cnt + GAP_W'(1);
                end
            end
            START: begin
                if (!mgmt_waitrequest) begin
                    w_write_nxt = 1'b1;
                    w_addr_nxt  = REG_START;
                    w_win_nxt   = '0;
                    w_seen_nxt  = 1'b0;
                    w_state_nxt = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (r_seen_busy) begin
                    if (!mgmt_waitrequest) begin
                        w_to_nxt    = '0;
                        w_state_nxt = WAIT_LOCK;
                    end
                end else if (mgmt_waitrequest) begin
                    w_seen_nxt = 1'b1;
                end else if (r_win_cnt == WIN_LAST) begin
                    w_to_nxt    = '0;
                    w_state_nxt = WAIT_LOCK;
                end else begin
                    w_win_nxt = r_win_cnt + WIN_W'(1);
                end
            end
            WAIT_LOCK: begin
                if (r_lock_s2) begin
                    w_lock_err_nxt = 1'b0;
                    w_done_nxt     = 1'b1;
                    w_state_nxt    = DONE;
                end else if (r_to_cnt == TO_LAST) begin
                    w_lock_err_nxt = 1'b1;
                    w_done_nxt     = 1'b1;
                    w_state_nxt    = DONE;
                end else begin
                    w_to_nxt = r_to_cnt + TO_W'(1);
                end
            end
            DONE: begin
                w_applied_nxt = r_target;
                w_busy_nxt    = 1'b0;
                w_state_nxt   = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign mgmt_write     = r_write;
    assign mgmt_address   = r_addr;
    assign mgmt_writedata = r_data;
    assign busy           = r_busy;
    assign done           = r_done;
    assign applied_sel    = r_applied;
    assign lock_err       = r_lock_err;

endmodule
`default_nettype wire

// File: tb/tb_pll_reconfig_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pll_reconfig_ctrl
// Description : Scoreboard bench for pll_reconfig_ctrl with a small pll_cfg
//               responder that raises waitrequest for 50 cycles after START.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_reconfig_ctrl;

    localparam int          GAP = 2;
    localparam int          LT  = 64;
    localparam logic [31:0] K0  = 32'd3639383488;
    localparam logic [31:0] K1  = 32'd3268298314;

    typedef struct packed {
        logic [5:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct packed {
        logic applied;
        logic err;
    } dn_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sel = 1'b0;
    logic        hold_wr = 1'b0;
    logic        model_busy = 1'b0;
    logic        pll_locked = 1'b1;
    logic        mgmt_waitrequest;
    logic        mgmt_write;
    logic [5:0]  mgmt_address;
    logic [31:0] mgmt_writedata;
    logic        busy;
    logic        done;
    logic        applied_sel;
    logic        lock_err;

    int          checks = 0;
    int          failures = 0;
    int unsigned cyc = 0;

    wr_t         exp_wr[$];
    dn_t         exp_dn[$];

    assign mgmt_waitrequest = hold_wr || model_busy;

    pll_reconfig_ctrl #(
        .LOCK_TIMEOUT (LT)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .sel              (sel),
        .mgmt_waitrequest (mgmt_waitrequest),
        .mgmt_write       (mgmt_write),
        .mgmt_address     (mgmt_address),
        .mgmt_writedata   (mgmt_writedata),
        .pll_locked       (pll_locked),
        .busy             (busy),
        .done             (done),
        .applied_sel      (applied_sel),
        .lock_err         (lock_err)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_seq(input logic [31:0] k, input logic app, input logic err);
        exp_wr.push_back('{addr: 6'd0, data: 32'd0});
        exp_wr.push_back('{addr: 6'd7, data: k});
        exp_wr.push_back('{addr: 6'd2, data: 32'd0});
        exp_dn.push_back('{applied: app, err: err});
    endtask

    task automatic wait_done(input string name, input int budget, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done && lat < budget);
        chk(name, done, 1);
    endtask

    task automatic wait_write(input string name, input logic [5:0] a, input int budget, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!(mgmt_write && mgmt_address == a) && lat < budget);
        chk(name, (mgmt_write && mgmt_address == a), 1);
    endtask

    // pll_cfg responder: reconfiguration runs for 50 cycles, starting the
    // cycle after the START write has been accepted.
    int   busy_cnt = 0;
    logic start_seen = 1'b0;
    always @(negedge clk) begin
        if (start_seen) begin
            busy_cnt = 50;
            start_seen = 1'b0;
        end
        if (mgmt_write && mgmt_address == 6'd2) start_seen = 1'b1;
        model_busy = (busy_cnt != 0);
        if (busy_cnt != 0) busy_cnt--;
    end

    // Monitor: pops expected writes and completions as the DUT presents them
    logic        done_d = 1'b0;
    logic        pend_applied = 1'b0;
    logic        have_last = 1'b0;
    int unsigned last_wr = 0;
    always @(negedge clk) begin
        wr_t w;
        dn_t d;
        if (mgmt_write) begin
            if (exp_wr.size() == 0) begin
                chk("unexpected_write_addr", {58'd0, mgmt_address}, 64'hFFFF);
            end else begin
                w = exp_wr.pop_front();
                chk("write_addr", {58'd0, mgmt_address}, {58'd0, w.addr});
                chk("write_data", {32'd0, mgmt_writedata}, {32'd0, w.data});
            end
            if (have_last) chk("write_spacing_ok", ((cyc - last_wr) >= GAP + 1), 1);
            last_wr = cyc;
            have_last = 1'b1;
        end else begin
            chk("idle_bus_zero", {26'd0, mgmt_address, mgmt_writedata}, 0);
        end
        if (done_d) begin
            chk("applied_after_done", applied_sel, pend_applied);
            chk("busy_after_done", busy, 0);
            chk("done_one_cycle", done, 0);
        end
        done_d = 1'b0;
        if (done) begin
            if (exp_dn.size() == 0) begin
                chk("unexpected_done", done, 0);
            end else begin
                d = exp_dn.pop_front();
                chk("lock_err_at_done", lock_err, d.err);
                chk("busy_at_done", busy, 1);
                pend_applied = d.applied;
                done_d = 1'b1;
            end
        end
    end

    // Stimulus
    initial begin
        int lat;
        int c0;

        // Reset state
        repeat (4) @(negedge clk);
        chk("rst_write", mgmt_write, 0);
        chk("rst_addr", mgmt_address, 0);
        chk("rst_data", mgmt_writedata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_applied", applied_sel, 0);
        chk("rst_lock_err", lock_err, 0);

        // Forced init sequence after reset release, sel=0
        push_seq(K0, 1'b0, 1'b0);
        reset = 1'b0;
        wait_done("init_done", 300, lat);
        repeat (2) @(negedge clk);

        // Single-cycle sel glitch must not start a sequence
        sel = 1'b1;
        @(negedge clk);
        sel = 1'b0;
        repeat (100) begin
            @(negedge clk);
            chk("glitch_busy", busy, 0);
        end

        // sel 0 -> 1 held
        push_seq(K1, 1'b1, 1'b0);
        sel = 1'b1;
        wait_write("sel1_mode_latency", 6'd0, 10, lat);
        wait_done("sel1_done", 300, lat);
        repeat (2) @(negedge clk);

        // waitrequest held high through MODE
        hold_wr = 1'b1;
        push_seq(K0, 1'b0, 1'b0);
        sel = 1'b0;
        repeat (45) begin
            @(negedge clk);
            chk("hold_no_write", mgmt_write, 0);
        end
        chk("hold_busy", busy, 1);
        hold_wr = 1'b0;
        @(negedge clk);
        chk("write_after_release", mgmt_write, 1);
        wait_done("hold_done", 300, lat);
        repeat (2) @(negedge clk);

        // sel changes back while waiting for lock
        pll_locked = 1'b0;
        push_seq(K1, 1'b1, 1'b0);
        push_seq(K0, 1'b0, 1'b0);
        sel = 1'b1;
        wait_write("midlock_start", 6'd2, 100, lat);
        repeat (53) @(negedge clk);
        sel = 1'b0;
        repeat (5) @(negedge clk);
        pll_locked = 1'b1;
        wait_done("midlock_done1", 100, lat);
        wait_done("midlock_done2", 300, lat);
        repeat (2) @(negedge clk);

        // Lock timeout: done 64 cycles after WAIT_LOCK entry, which is
        // 52 cycles after the START write with this responder
        pll_locked = 1'b0;
        push_seq(K1, 1'b1, 1'b1);
        sel = 1'b1;
        wait_write("timeout_start", 6'd2, 100, lat);
        wait_done("timeout_done", 200, lat);
        chk("timeout_latency", lat, 52 + LT);
        repeat (2) @(negedge clk);
        chk("lock_err_sticky", lock_err, 1);

        // Successful sequence clears lock_err
        pll_locked = 1'b1;
        push_seq(K0, 1'b0, 1'b0);
        sel = 1'b0;
        wait_done("recover_done", 300, lat);
        repeat (2) @(negedge clk);
        chk("lock_err_cleared", lock_err, 0);

        // Reset while in KFRAC, then full reprogram of current sel
        exp_wr.push_back('{addr: 6'd0, data: 32'd0});
        push_seq(K1, 1'b1, 1'b0);
        sel = 1'b1;
        wait_write("rst_mid_mode", 6'd0, 20, lat);
        c0 = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) begin
            @(negedge clk);
            c0++;
            chk("rst_mid_no_write", mgmt_write, 0);
            chk("rst_mid_busy", busy, 0);
        end
        reset = 1'b0;
        wait_done("rst_reprog_done", 400, lat);
        repeat (3) @(negedge clk);
        chk("rst_reprog_applied", applied_sel, 1);

        chk("wr_queue_empty", exp_wr.size(), 0);
        chk("done_queue_empty", exp_dn.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #(20 * 40000);
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
